arithmetic_left_shift_of_n_saturating_serial: RTL and testbench
===============================================================

Name: arithmetic_left_shift_of_N_saturating_serial

Overview:
Iterative signed multiply-by-power-of-two, the counterpart of the arithmetic right shift (signed divide by 2^S) blocks. It accepts a signed N-bit operand and a variable shift amount over a valid/ready handshake and shifts left one bit per clock. On signed overflow it saturates to the most positive or most negative value and flags the overflow. It sits in the arithmetic datapath as the scale-up stage facing the divide-by-2^S stage.

Parameters:
N, 8, operand/result width in bits (N >= 2)
SW, 4, width of shift-amount input; maximum shift 2^SW - 1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand/shamt valid
in_ready  output  1  block can accept operand
a  input  N  signed operand, two's complement
shamt  input  SW  unsigned left-shift amount
out_valid  output  1  res/ovf valid
out_ready  input  1  consumer accepts result
res  output  N  signed result, a * 2^shamt or saturated value
ovf  output  1  1 = result was saturated

Behaviour:
- Reset is asynchronous and active-high. While rst=1 and after it: state=IDLE, acc=0, cnt=0, out_valid=0, res=0, ovf=0, in_ready=0. in_ready rises in the first cycle after rst deasserts.
- in_ready=1 only in IDLE with rst=0. The block never overlaps operations.
- FSM states IDLE, SHIFT, DONE:
  - IDLE: on in_valid&in_ready, load acc=a, cnt=shamt, sign=a[N-1], ovf_r=0. Go to DONE if shamt==0, else to SHIFT.
  - SHIFT: each edge, test acc[N-1] vs acc[N-2].
    - Equal: acc <= acc<<1 (LSB 0), cnt <= cnt-1. Go to DONE when cnt==1, else stay.
    - Differ (next shift would overflow): acc <= sign ? {1'b1,{N-1{1'b0}}} : {1'b0,{N-1{1'b1}}}, ovf_r <= 1, go to DONE immediately (early exit).
  - DONE: out_valid=1, res=acc, ovf=ovf_r. Hold all three stable until out_ready=1. On the out_valid&out_ready edge, go to IDLE.
- Latency, with the accept edge at cycle T:
  - no overflow: out_valid asserts at T+1+shamt;
  - overflow detected at the j-th SHIFT cycle (j=1..shamt): out_valid asserts at T+1+j.
- a and shamt are sampled only on the accept edge; later changes are ignored.
- a=0 with any shamt: res=0, ovf=0, full shamt cycles (no early exit).
- Most-negative input (-2^(N-1)) with shamt>=1 saturates on the first SHIFT cycle.
- shamt >= N with nonzero a always overflows before cnt expires.
- Backpressure: out_ready low holds DONE indefinitely; in_ready stays 0 throughout.
- out_valid and out_ready may rise in the same cycle. Next accept is possible one cycle after the output handshake (IDLE cycle). No combinational in_valid->out_valid path.
- rst asserted mid-operation (SHIFT or DONE) abandons the operation. No output handshake occurs. State returns to reset values immediately.
- Arithmetic: results are exact two's complement when no overflow. Saturation targets are +2^(N-1)-1 and -2^(N-1), selected by the operand's original sign.

Test Plan:
- N=8: a=3, shamt=2, out_ready=1 -> res=12 (8'b00001100), ovf=0, out_valid at T+3 for exactly one cycle; in_ready=1 at T+4.
- a=-5 (8'hFB), shamt=3 -> res=-40 (8'hD8), ovf=0; a=-1, shamt=7 -> res=-128 (8'h80), ovf=0, out_valid at T+8.
- a=100 (8'h64), shamt=1 -> res=127 (8'h7F), ovf=1, out_valid at T+2; a=-128, shamt=1 -> res=8'h80, ovf=1 at T+2; a=-3, shamt=15 -> res=8'h80, ovf=1 via early exit well before T+16.
- a=0, shamt=15 -> res=0, ovf=0, out_valid at T+16; a=77, shamt=0 -> res=77, ovf=0, out_valid at T+1.
- Backpressure: a=5, shamt=1, out_ready=0 for 5 cycles -> res=10 held stable with out_valid=1; in_ready=0; a/shamt toggled during the hold have no effect; single handshake on out_ready=1.
- Reset: pulse rst asynchronously (between edges) during SHIFT of a=1, shamt=6 -> out_valid, res, ovf go 0 without waiting for a clock edge; no output handshake; after release, a=2, shamt=2 -> res=8 at T+3.

Source files
------------

// File: rtl/arithmetic_left_shift_of_n_saturating_serial.sv
// Purpose    : signed multiply by 2^shamt, one left shift per clock, saturating on signed overflow.
// Latency    : result valid shamt+1 cycles after accept, or j+1 cycles when overflow is seen on shift j.
// Backpressure: result held in DONE until out_ready; in_ready low for the whole operation.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operand handshake (a: signed N-bit, shamt: unsigned SW-bit)
//   out_valid/out_ready  result handshake (res: signed N-bit, ovf: result was saturated)
module arithmetic_left_shift_of_n_saturating_serial #(
    parameter int N  = 8,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] shamt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  res,
    output logic          ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};

    state_t        state, state_nxt;
    logic [N-1:0]  acc, acc_nxt;
    logic [SW-1:0] cnt, cnt_nxt;
    logic          sign, sign_nxt;
    logic          ovf_r, ovf_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sign  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            sign  <= sign_nxt;
            ovf_r <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        sign_nxt  = sign;
        ovf_nxt   = ovf_r;
        case (state)
            IDLE: begin
                if (in_valid && !rst) begin
                    acc_nxt   = a;
                    cnt_nxt   = shamt;
                    sign_nxt  = a[N-1];
                    ovf_nxt   = 1'b0;
                    state_nxt = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Top two bits differing means the next shift would change the
                // sign, so saturate now instead of spending the remaining cycles.
                if (acc[N-1] != acc[N-2]) begin
                    acc_nxt   = sign ? SAT_NEG : SAT_POS;
                    ovf_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    acc_nxt = {acc[N-2:0], 1'b0};
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == SW'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the state register only, so there is no
    // combinational path from in_valid to out_valid.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign res       = (state == DONE) ? acc : '0;
    assign ovf       = (state == DONE) ? ovf_r : 1'b0;

endmodule

// File: tb/tb_arithmetic_left_shift_of_n_saturating_serial.sv
module tb_arithmetic_left_shift_of_n_saturating_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'd0;
    logic [3:0] shamt = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] res;
    logic       ovf;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] res;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];

    arithmetic_left_shift_of_n_saturating_serial #(.N(8), .SW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: exact product a*2^sh; overflow cycle j is the first j whose
    // product leaves the signed 8-bit range.
    function automatic exp_t model(input logic [7:0] av, input logic [3:0] sh);
        exp_t   e;
        longint v;
        longint p;
        logic   hit;
        v     = longint'($signed(av));
        hit   = 1'b0;
        e.lat = int'(sh);
        e.ovf = 1'b0;
        e.res = 8'(v * (longint'(1) << sh));
        for (int j = 1; j <= int'(sh); j++) begin
            p = v * (longint'(1) << j);
            if (!hit && (p > 127 || p < -128)) begin
                hit   = 1'b1;
                e.ovf = 1'b1;
                e.lat = j;
                e.res = (v < 0) ? 8'h80 : 8'h7F;
            end
        end
        return e;
    endfunction

    // Called 1 time unit after an edge with the DUT idle; returns 1 time unit
    // after the accept edge.
    task automatic start_op(input logic [7:0] av, input logic [3:0] sh);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL start_in_ready a=%0h sh=%0d got %b want 1", av, sh, in_ready);
        else passed++;
        a        = av;
        shamt    = sh;
        in_valid = 1'b1;
        sb.push_back(model(av, sh));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        shamt    = 4'($urandom);
    endtask

    // Waits for the result, checks latency/value, holds for 'hold' cycles with
    // out_ready low, then completes the handshake.
    task automatic finish_op(input string name, input int hold);
        exp_t       e;
        int         k;
        logic [7:0] held;
        k = 0;
        e = sb.pop_front();
        if (hold > 0) out_ready = 1'b0;
        while (out_valid !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            $display("FAIL %s_timeout out_valid never rose within %0d cycles", name, k);
            out_ready = 1'b1;
            return;
        end
        passed++;
        checks++;
        if (k !== e.lat) $display("FAIL %s_latency got T+%0d want T+%0d", name, k + 1, e.lat + 1);
        else passed++;
        checks++;
        if (res !== e.res || ovf !== e.ovf)
            $display("FAIL %s_result got res=%h ovf=%b want res=%h ovf=%b", name, res, ovf, e.res, e.ovf);
        else passed++;
        held = res;
        for (int i = 0; i < hold; i++) begin
            a        = 8'($urandom);
            shamt    = 4'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || res !== held || in_ready !== 1'b0)
                $display("FAIL %s_hold%0d got vld=%b res=%h rdy=%b want vld=1 res=%h rdy=0",
                         name, i, out_valid, res, in_ready, held);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s_after_hs got vld=%b rdy=%b want vld=0 rdy=1", name, out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (out_valid !== 1'b0 || res !== 8'd0 || ovf !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_outputs got vld=%b res=%h ovf=%b rdy=%b want all 0", out_valid, res, ovf, in_ready);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_rdy got %b want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_exact;
        start_op(8'd3, 4'd2);    finish_op("a3_s2", 0);
        start_op(8'hFB, 4'd3);   finish_op("am5_s3", 0);
        start_op(8'hFF, 4'd7);   finish_op("am1_s7", 0);
        start_op(8'd77, 4'd0);   finish_op("a77_s0", 0);
        start_op(8'd0, 4'd15);   finish_op("a0_s15", 0);
    endtask

    task automatic test_overflow;
        start_op(8'd100, 4'd1);  finish_op("a100_s1", 0);
        start_op(8'h80, 4'd1);   finish_op("am128_s1", 0);
        start_op(8'hFD, 4'd15);  finish_op("am3_s15", 0);
        start_op(8'd1, 4'd9);    finish_op("a1_s9", 0);
        start_op(8'h3F, 4'd1);   finish_op("a63_s1", 0);
        start_op(8'h40, 4'd1);   finish_op("a64_s1", 0);
    endtask

    task automatic test_backpressure;
        start_op(8'd5, 4'd1);
        in_valid = 1'b1;
        finish_op("bp_a5_s1", 5);
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            start_op(8'($urandom), 4'($urandom_range(0, 9)));
            finish_op("b2b", 0);
        end
    endtask

    task automatic test_mid_reset;
        // Reset during SHIFT.
        start_op(8'd1, 4'd6);
        void'(sb.pop_back());
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || res !== 8'd0 || ovf !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rst_shift got vld=%b res=%h ovf=%b rdy=%b want all 0", out_valid, res, ovf, in_ready);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL rst_shift_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        else passed++;
        @(posedge clk); #1;
        // Reset while holding a result in DONE must drop it between edges.
        out_ready = 1'b0;
        start_op(8'h55, 4'd0);
        void'(sb.pop_back());
        checks++;
        if (out_valid !== 1'b1 || res !== 8'h55)
            $display("FAIL rst_done_setup got vld=%b res=%h want vld=1 res=55", out_valid, res);
        else passed++;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || res !== 8'd0 || ovf !== 1'b0)
            $display("FAIL rst_done got vld=%b res=%h ovf=%b want all 0", out_valid, res, ovf);
        else passed++;
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start_op(8'd2, 4'd2);
        finish_op("post_rst_a2_s2", 0);
    endtask

    initial begin
        test_reset();
        test_exact();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
